// File: rtl/sram_port_arbiter_pkg.sv
// sram_arb_pkg: shared types and sizing helpers for the SRAM port arbiter.
package sram_arb_pkg;
  typedef enum logic {ROUND_ROBIN = 1'b0, LOCKED = 1'b1} state_t;
  localparam int BURST_W = 8;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// rr_pick: circular priority select, first set request at or after start.
module rr_pick #(
  parameter int N = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(start) + k) % N]) begin
        any = 1'b1;
        idx = IDX_W'((int'(start) + k) % N);
        grant[(int'(start) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter with bounded lock bursts sharing one
// single-port SRAM, routing 1-cycle read data back to the issuing requester.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NUM_REQ = 2,
  parameter int MAX_BURST = 4,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic                      sram_ren,
  output logic                      sram_wen,
  output logic [WIDTH-1:0]          sram_d,
  input  logic [WIDTH-1:0]          sram_q
);
  state_t             state;
  logic [IDX_W-1:0]   rr_ptr, owner, g, next_ptr, tag_idx;
  logic [BURST_W-1:0] burst_cnt;
  logic               tag_v, xfer, lock_ok, burst_more;
  logic [NUM_REQ-1:0] valid_eff, mask;
  // A locked owner that drops valid falls back to round robin in the same cycle.
  assign valid_eff = rst ? '0 : req_valid;
  assign lock_ok = (state == LOCKED) && valid_eff[owner];
  assign mask = lock_ok ? (valid_eff & (NUM_REQ'(1) << owner)) : valid_eff;
  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(mask),
    .start(lock_ok ? owner : rr_ptr),
    .grant(req_ready),
    .idx(g),
    .any(xfer)
  );
  assign next_ptr = (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign burst_more = ({1'b0, burst_cnt} + 9'd1) < 9'(MAX_BURST);
  assign sram_ren = xfer && !req_write[g];
  assign sram_wen = xfer && req_write[g];
  assign sram_addr = xfer ? req_addr[g*ADDR_W +: ADDR_W] : '0;
  assign sram_d = xfer ? req_wdata[g*WIDTH +: WIDTH] : '0;
  assign rsp_valid = tag_v ? (NUM_REQ'(1) << tag_idx) : '0;
  assign rsp_data = tag_v ? sram_q : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ROUND_ROBIN;
      rr_ptr <= '0;
      owner <= '0;
      burst_cnt <= '0;
      tag_v <= 1'b0;
      tag_idx <= '0;
    end else begin
      tag_v <= sram_ren;
      tag_idx <= g;
      if (xfer) rr_ptr <= next_ptr;
      if (lock_ok) begin
        state <= (req_lock[g] && burst_more) ? LOCKED : ROUND_ROBIN;
        burst_cnt <= (req_lock[g] && burst_more) ? burst_cnt + 1'b1 : '0;
      end else begin
        state <= (xfer && req_lock[g] && MAX_BURST > 1) ? LOCKED : ROUND_ROBIN;
        burst_cnt <= (xfer && req_lock[g] && MAX_BURST > 1) ? BURST_W'(1) : '0;
        owner <= g;
      end
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (sram_ren && sram_wen) begin
      $display("sram_port_arbiter: error, sram_ren and sram_wen both asserted");
      $finish(1);
    end
  end
`endif
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one `single_port_sram` instance between NUM_REQ requesters using round-robin arbitration with bounded bursts.
- Guarantees ren and wen are never asserted in the same cycle.
- Issues at most one SRAM operation per cycle.
- Routes the registered read data back to the requester that issued the read.
- Sits between the loop-sequencing control (counters and shift registers) and the SRAM.

Parameters:
- WIDTH, 32: SRAM data width.
- DEPTH, 32: SRAM depth. ADDR_W = $clog2(DEPTH) (localparam).
- NUM_REQ, 2: number of requesters, 2..8.
- MAX_BURST, 4: maximum consecutive grants to one locked requester before a forced handoff, 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has an operation pending.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_lock  in  NUM_REQ  requester i asks to keep the grant next cycle.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i is [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; the operation is accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot; rsp_data belongs to requester i.
- rsp_data  out  WIDTH  read data.
- sram_addr  out  ADDR_W  to SRAM addr.
- sram_ren  out  1  to SRAM ren.
- sram_wen  out  1  to SRAM wen.
- sram_d  out  WIDTH  to SRAM d.
- sram_q  in  WIDTH  from SRAM q.

Behaviour:
- Handshake:
  - Transfer happens when req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid and the registered state.
  - Requesters hold addr, data and write stable until the transfer.
- Grant rules:
  - At most one req_ready bit is high per cycle.
  - req_ready is never high for a requester whose req_valid is low.
  - If any req_valid is high, exactly one grant is issued; the arbiter is work-conserving.
- State machine, 2 states:
  - ROUND_ROBIN: grant the first valid requester at or after rr_ptr (circular search). On a transfer, rr_ptr <= granted+1 mod NUM_REQ. If req_lock[g] is high, go to LOCKED with owner <= g and burst_cnt <= 1.
  - LOCKED: only the owner may be granted.
    - Owner transfers with req_lock high and burst_cnt < MAX_BURST: stay in LOCKED, burst_cnt++.
    - Owner transfers with lock low, or burst_cnt reaches MAX_BURST on this transfer: return to ROUND_ROBIN, rr_ptr <= owner+1.
    - Owner's req_valid low in any LOCKED cycle: return to ROUND_ROBIN immediately. That cycle is arbitrated as ROUND_ROBIN, so no bubble. The lock is lost.
- MAX_BURST = 1: lock never persists beyond the single grant.
- SRAM drive (combinational):
  - sram_ren = transfer & !req_write[g]; sram_wen = transfer & req_write[g].
  - sram_addr and sram_d come from the granted slice. When idle, sram_addr = 0 and sram_d = 0.
- Read return:
  - Read latency is exactly 1 cycle: a read accepted in cycle t gives rsp_valid[g] = 1 in cycle t+1 with rsp_data = sram_q.
  - A 1-deep tag register (valid bit plus requester index) tracks this.
  - Back-to-back reads give a response every cycle.
  - rsp_data = 0 when no rsp_valid is high. The SRAM's dummy value is never forwarded.
- Write then read of the same address in consecutive cycles returns the new data. No stall and no forwarding; the SRAM commits the write before the read samples.
- Reset values:
  - state = ROUND_ROBIN, rr_ptr = 0, burst_cnt = 0, response tag invalid.
  - Outputs during and after reset: req_ready = 0, rsp_valid = 0, rsp_data = 0, sram_ren = 0, sram_wen = 0.
- Reset mid-operation: a pending read response is dropped, with no rsp_valid after reset deassertion, and any lock is released.
- Assertion (simulation only): sram_ren & sram_wen → $display error and $finish(1).

Decomposition:
- Package sram_arb_pkg holds:
  - state encoding constant: ROUND_ROBIN = 0, LOCKED = 1;
  - the ADDR_W helper function;
  - the MAX_BURST counter width (8 bits).
- Sub-module rr_pick: combinational circular priority select (req vector, start pointer → one-hot grant and index). It is reused for both arbitration modes by masking.

Test Plan:
- Single requester reads: write 0xDEAD to addr 5 via req0, then read addr 5 via req0 → req_ready[0] in each cycle; rsp_valid[0] = 1 exactly one cycle after the read with rsp_data = 0xDEAD; no rsp_valid after the write.
- Contention: req0 and req1 both valid for 6 cycles, no lock → grants alternate 0,1,0,1,0,1; sram_ren & sram_wen never both high.
- Burst lock: MAX_BURST = 4, req0 locked and valid, req1 valid → req0 granted 4 cycles, then req1 granted in cycle 5, then req0 again.
- Lock drop: req0 locked, then deasserts req_valid in its 2nd locked cycle while req1 is valid → req1 granted in that same cycle.
- Write-then-read: write 0x1234 to addr 7 in cycle t, read addr 7 in cycle t+1 → rsp_data = 0x1234 at t+2.
- Async reset mid-read: assert rst between a read accept and its response → rsp_valid stays 0 during and after reset; the next read after reset behaves normally, rr_ptr = 0.
